// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg - shared types and constants for the uart_rx_monitor slice.
`default_nettype none

package uart_mon_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_mon_fifo.sv
// uart_mon_fifo - synchronous show-ahead FIFO; head word is visible on head_data whenever !empty.
`default_nettype none

module uart_mon_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor - cycle-exact UART 8N1 receiver feeding a byte FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to receive 8E1 (even parity) frames instead.
`default_nettype none

module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rxd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [UART_DATA_BITS-1:0]     out_data,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  state_e                    state_q, state_d;
  logic                      meta_q, meta_d;
  logic                      rx_s_q, rx_s_d;
  logic                      rx_q, rx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_err_q, par_err_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overflow_q, overflow_d;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_comb begin
    meta_d = rxd;
    rx_s_d = meta_q;
    rx_d   = rx_s_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        // Requiring rx_q high means a line held low after a bad frame cannot restart.
        cnt_d = '0;
        if (rx_q && !rx_s_q) begin
          state_d   = START;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rx_s_q};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q && !par_err_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop        = out_valid && out_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_q        <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      rx_s_q      <= rx_s_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  uart_mon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor - directed self-checking bench for uart_rx_monitor (8 clocks/bit, 4-entry FIFO).
`default_nettype none

module tb_uart_rx_monitor;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_LAT = 2 + 84 + 1;
`else
  localparam int FRAME_LAT = 2 + 76 + 1;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       rxd       = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_count;
  logic       busy;

  int checks    = 0;
  int fails     = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int rx_n      = 0;
  int fe_count  = 0;
  logic [7:0] rx_data [64];
  int         rx_cyc  [64];

  uart_rx_monitor #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every accepted byte and every frame_err pulse, sampled mid-cycle.
  always begin
    @(negedge clock);
    #1;
    if (out_valid && out_ready && rx_n < 64) begin
      rx_data[rx_n] = out_data;
      rx_cyc[rx_n]  = cyc;
      rx_n          = rx_n + 1;
    end
    if (frame_err) fe_count = fe_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Must be called at a negedge; returns at a negedge with rxd left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd       = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^b;
    repeat (CPB) @(negedge clock);
`endif
    rxd = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    rxd       = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_byte;
    int n0;
    int fe0;
    n0        = rx_n;
    fe0       = fe_count;
    out_ready = 1'b1;
    @(negedge clock);
    send_frame(8'h55, 1'b1);
    rxd = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (rx_n !== n0 + 1) begin fails++; $display("FAIL single_count: got %0d want %0d", rx_n - n0, 1); end
    checks++; if (rx_data[n0] !== 8'h55) begin fails++; $display("FAIL single_data: got %h want 55", rx_data[n0]); end
    checks++; if (rx_cyc[n0] - start_cyc !== FRAME_LAT) begin fails++; $display("FAIL single_latency: got %0d want %0d", rx_cyc[n0] - start_cyc, FRAME_LAT); end
    checks++; if (fe_count !== fe0) begin fails++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_count - fe0); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0        = rx_n;
    out_ready = 1'b0;
    @(negedge clock);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    repeat (5) @(negedge clock);
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL b2b_head_stable: got %h want 00", out_data); end
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (rx_n !== n0 + 2) begin fails++; $display("FAIL b2b_pops: got %0d want 2", rx_n - n0); end
    checks++; if (rx_data[n0] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", rx_data[n0]); end
    checks++; if (rx_data[n0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", rx_data[n0+1]); end
    checks++; if (rx_cyc[n0+1] !== rx_cyc[n0] + 1) begin fails++; $display("FAIL b2b_consecutive: got gap %0d want 1", rx_cyc[n0+1] - rx_cyc[n0]); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL b2b_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_frame_error;
    int   n0;
    int   fe0;
    logic busy_seen;
    n0        = rx_n;
    fe0       = fe_count;
    out_ready = 1'b1;
    @(negedge clock);
    send_frame(8'hA5, 1'b0);
    repeat (2) @(negedge clock);
    checks++; if (fe_count !== fe0 + 1) begin fails++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_count - fe0); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL ferr_count: got %0d want 0", fifo_count); end
    checks++; if (rx_n !== n0) begin fails++; $display("FAIL ferr_dropped: got %0d bytes want 0", rx_n - n0); end
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL break_retrigger: busy seen %b want 0", busy_seen); end
    rxd = 1'b1;
    repeat (4) @(negedge clock);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    checks++; if (rx_n !== n0 + 1) begin fails++; $display("FAIL recover_count: got %0d want 1", rx_n - n0); end
    checks++; if (rx_data[n0] !== 8'h3C) begin fails++; $display("FAIL recover_data: got %h want 3c", rx_data[n0]); end
    checks++; if (fe_count !== fe0 + 1) begin fails++; $display("FAIL recover_ferr: got %0d pulses want 1", fe_count - fe0); end
  endtask

  task automatic test_glitch;
    int   n0;
    int   fe0;
    logic busy_seen;
    n0  = rx_n;
    fe0 = fe_count;
    @(negedge clock);
    rxd = 1'b0;
    repeat (2) @(negedge clock);
    rxd       = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise: got %b want 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
    checks++; if (rx_n !== n0) begin fails++; $display("FAIL glitch_push: got %0d bytes want 0", rx_n - n0); end
    checks++; if (fe_count !== fe0) begin fails++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_count - fe0); end
  endtask

  task automatic test_overflow;
    int         n0;
    logic [7:0] b;
    n0        = rx_n;
    out_ready = 1'b0;
    @(negedge clock);
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    checks++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_full_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", overflow); end
    send_frame(8'h05, 1'b1);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (out_data !== 8'h01) begin fails++; $display("FAIL ovf_head: got %h want 01", out_data); end
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    out_ready = 1'b0;
    checks++; if (rx_n !== n0 + 4) begin fails++; $display("FAIL ovf_drain_count: got %0d want 4", rx_n - n0); end
    for (int i = 0; i < 4; i++) begin
      b = 8'(i + 1);
      checks++; if (rx_data[n0+i] !== b) begin fails++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, rx_data[n0+i], b); end
    end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_frame;
    int         n0;
    int         fe0;
    logic [7:0] b;
    out_ready = 1'b0;
    @(negedge clock);
    send_frame(8'h99, 1'b1);
    repeat (2) @(negedge clock);
    checks++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL mid_preload: got %0d want 1", fifo_count); end
    n0  = rx_n;
    fe0 = fe_count;
    b   = 8'h7E;
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = b[3];
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL mid_frame_err: got %b want 0", frame_err); end
    rxd       = 1'b1;
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (100) @(negedge clock);
    checks++; if (rx_n !== n0) begin fails++; $display("FAIL mid_no_push: got %0d bytes want 0", rx_n - n0); end
    checks++; if (fe_count !== fe0) begin fails++; $display("FAIL mid_no_ferr: got %0d pulses want 0", fe_count - fe0); end
    send_frame(8'h42, 1'b1);
    repeat (4) @(negedge clock);
    checks++; if (rx_n !== n0 + 1) begin fails++; $display("FAIL post_reset_count: got %0d want 1", rx_n - n0); end
    checks++; if (rx_data[n0] !== 8'h42) begin fails++; $display("FAIL post_reset_data: got %h want 42", rx_data[n0]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int         n0;
    int         fe0;
    logic [7:0] b;
    n0        = rx_n;
    fe0       = fe_count;
    b         = 8'h07;
    out_ready = 1'b1;
    @(negedge clock);
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    rxd = 1'b1;
    repeat (CPB + 4) @(negedge clock);
    checks++; if (fe_count !== fe0 + 1) begin fails++; $display("FAIL parity_ferr: got %0d pulses want 1", fe_count - fe0); end
    checks++; if (rx_n !== n0) begin fails++; $display("FAIL parity_dropped: got %0d bytes want 0", rx_n - n0); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL parity_count: got %0d want 0", fifo_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
